// File: rtl/raster_pixel_source_if.sv
// Pixel stream bundle between raster_pixel_source and its consumer.
// The source presents pixel_out plus line/frame markers; the consumer throttles via out_ready.
interface raster_pixel_source_if #(
  parameter int DATA_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  data_valid;
  logic                  sol;
  logic                  eol;
  logic                  sof;
  logic                  eof;
  logic                  out_ready;

  modport master (
    output pixel_out, data_valid, sol, eol, sof, eof,
    input  out_ready
  );

  modport slave (
    input  pixel_out, data_valid, sol, eol, sof, eof,
    output out_ready
  );
endinterface

// File: rtl/raster_pixel_source.sv
// Raster-scan test-pattern source: one LINE_WIDTH x FRAME_HEIGHT frame at a time with
// horizontal/vertical blanking, line/frame markers and valid/ready throttling.
module raster_pixel_source #(
  parameter int LINE_WIDTH   = 10,
  parameter int FRAME_HEIGHT = 5,
  parameter int DATA_WIDTH   = 6,
  parameter int H_BLANK      = 2,
  parameter int V_BLANK      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             pattern_sel,
  output logic [7:0]             frame_cnt,
  raster_pixel_source_if.master  px
);

  localparam int HW   = $clog2(LINE_WIDTH);
  localparam int VW   = $clog2(FRAME_HEIGHT);
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = (BMAX < 2) ? 1 : $clog2(BMAX);

  localparam logic [HW-1:0]         H_LAST = HW'(LINE_WIDTH - 1);
  localparam logic [VW-1:0]         V_LAST = VW'(FRAME_HEIGHT - 1);
  localparam logic [BW-1:0]         H_LOAD = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [BW-1:0]         V_LOAD = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);
  localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t          state_q, state_n;
  logic [HW-1:0]   h_cnt, h_n;
  logic [VW-1:0]   v_cnt, v_n;
  logic [BW-1:0]   blank_cnt, blank_n;
  logic [1:0]      pat_q, pat_n;
  logic [7:0]      frame_n;

  function automatic logic [DATA_WIDTH-1:0] pixel_value(input logic [1:0]    pat,
                                                        input logic [HW-1:0] h,
                                                        input logic [VW-1:0] v);
    int hi;
    int vi;
    int idx;
    hi  = int'(h);
    vi  = int'(v);
    idx = hi + vi * LINE_WIDTH;
    case (pat)
      2'd0:    return DATA_WIDTH'(idx);
      2'd1:    return DATA_WIDTH'(hi);
      2'd2:    return (hi >= LINE_WIDTH / 2) ? PIX_MAX : '0;
      default: return ((((hi >> 1) ^ (vi >> 1)) & 1) != 0) ? PIX_MAX : '0;
    endcase
  endfunction

  // Next-state logic; the counters always name the pixel to be presented while ACTIVE.
  always_comb begin
    state_n = state_q;
    h_n     = h_cnt;
    v_n     = v_cnt;
    blank_n = blank_cnt;
    pat_n   = pat_q;
    frame_n = frame_cnt;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_n = ACTIVE;
          h_n     = '0;
          v_n     = '0;
          pat_n   = pattern_sel;
        end
      end
      ACTIVE: begin
        if (px.out_ready) begin
          if (h_cnt != H_LAST) begin
            h_n = h_cnt + 1'b1;
          end else if (v_cnt != V_LAST) begin
            h_n = '0;
            v_n = v_cnt + 1'b1;
            if (H_BLANK > 0) begin
              state_n = HBLANK;
              blank_n = H_LOAD;
            end
          end else begin
            h_n     = '0;
            v_n     = '0;
            frame_n = frame_cnt + 1'b1;
            if (V_BLANK > 0) begin
              state_n = VBLANK;
              blank_n = V_LOAD;
            end else if (enable) begin
              pat_n = pattern_sel;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      HBLANK: begin
        if (blank_cnt == '0) state_n = ACTIVE;
        else                 blank_n = blank_cnt - 1'b1;
      end
      VBLANK: begin
        if (blank_cnt == '0) begin
          if (enable) begin
            state_n = ACTIVE;
            pat_n   = pattern_sel;
          end else begin
            state_n = IDLE;
          end
        end else begin
          blank_n = blank_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic                  vld_n;
  logic [DATA_WIDTH-1:0] pix_n;

  always_comb begin
    vld_n = (state_n == ACTIVE);
    pix_n = vld_n ? pixel_value(pat_n, h_n, v_n) : '0;
  end

  // Registered output stage: outputs reflect the state/counters just entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      h_cnt         <= '0;
      v_cnt         <= '0;
      blank_cnt     <= '0;
      pat_q         <= '0;
      frame_cnt     <= '0;
      px.data_valid <= 1'b0;
      px.pixel_out  <= '0;
      px.sol        <= 1'b0;
      px.eol        <= 1'b0;
      px.sof        <= 1'b0;
      px.eof        <= 1'b0;
    end else begin
      state_q       <= state_n;
      h_cnt         <= h_n;
      v_cnt         <= v_n;
      blank_cnt     <= blank_n;
      pat_q         <= pat_n;
      frame_cnt     <= frame_n;
      px.data_valid <= vld_n;
      px.pixel_out  <= pix_n;
      px.sol        <= vld_n && (h_n == '0);
      px.eol        <= vld_n && (h_n == H_LAST);
      px.sof        <= vld_n && (h_n == '0) && (v_n == '0);
      px.eof        <= vld_n && (h_n == H_LAST) && (v_n == V_LAST);
    end
  end

endmodule

// File: tb/tb_raster_pixel_source.sv
// Bench for raster_pixel_source: two instances (with and without blanking) share stimulus and
// are compared every cycle against a slot-timeline model, plus directed literal checks.
module tb_raster_pixel_source;
  localparam int LW = 10;
  localparam int FH = 5;
  localparam int DW = 6;
  localparam int PMAX = 63;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       out_ready;
  logic [7:0] fc_a, fc_b;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 0;

  always #5 clk = ~clk;

  raster_pixel_source_if #(.DATA_WIDTH(DW)) ifa ();
  raster_pixel_source_if #(.DATA_WIDTH(DW)) ifb ();
  assign ifa.out_ready = out_ready;
  assign ifb.out_ready = out_ready;

  raster_pixel_source #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .DATA_WIDTH(DW),
                        .H_BLANK(2), .V_BLANK(4)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .frame_cnt(fc_a), .px(ifa));

  raster_pixel_source #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .DATA_WIDTH(DW),
                        .H_BLANK(0), .V_BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .frame_cnt(fc_b), .px(ifb));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Frame timeline: each frame is a fixed list of slots (pixels, then blanking gaps).
  function automatic int hb(input int k); return (k == 0) ? 2 : 0; endfunction
  function automatic int vb(input int k); return (k == 0) ? 4 : 0; endfunction
  function automatic int ls(input int k); return LW + hb(k); endfunction
  function automatic int slots(input int k); return (FH - 1) * ls(k) + LW + vb(k); endfunction
  function automatic int slot_v(input int p, input int k);
    int v = p / ls(k);
    return (v > FH - 1) ? FH - 1 : v;
  endfunction
  function automatic int slot_h(input int p, input int k);
    return p - slot_v(p, k) * ls(k);
  endfunction
  function automatic bit is_pix(input int p, input int k);
    return slot_h(p, k) < LW;
  endfunction
  function automatic int exp_pixel(input int pat, input int h, input int v);
    case (pat)
      0:       return (h + v * LW) % (1 << DW);
      1:       return h % (1 << DW);
      2:       return (h >= LW / 2) ? PMAX : 0;
      default: return ((((h / 2) % 2) != ((v / 2) % 2))) ? PMAX : 0;
    endcase
  endfunction

  bit run    [2];
  int pos    [2];
  int frames [2];
  int pat    [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        run[k]    <= 1'b0;
        pos[k]    <= 0;
        frames[k] <= 0;
      end else if (!run[k]) begin
        if (enable) begin
          run[k] <= 1'b1;
          pos[k] <= 0;
          pat[k] <= int'(pattern_sel);
        end
      end else if (!is_pix(pos[k], k) || out_ready) begin
        if (pos[k] == (FH - 1) * ls(k) + LW - 1) frames[k] <= (frames[k] + 1) % 256;
        if (pos[k] + 1 == slots(k)) begin
          pos[k] <= 0;
          if (enable) pat[k] <= int'(pattern_sel);
          else        run[k] <= 1'b0;
        end else begin
          pos[k] <= pos[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        int  h, v, ef, af, apix, aval, afc;
        bit  ev;
        ev   = run[k] && is_pix(pos[k], k);
        h    = slot_h(pos[k], k);
        v    = slot_v(pos[k], k);
        aval = (k == 0) ? int'(ifa.data_valid) : int'(ifb.data_valid);
        apix = (k == 0) ? int'(ifa.pixel_out) : int'(ifb.pixel_out);
        af   = (k == 0) ? int'({ifa.sof, ifa.sol, ifa.eol, ifa.eof})
                        : int'({ifb.sof, ifb.sol, ifb.eol, ifb.eof});
        afc  = (k == 0) ? int'(fc_a) : int'(fc_b);
        check(k == 0 ? "a.valid" : "b.valid", aval, int'(ev));
        check(k == 0 ? "a.frame_cnt" : "b.frame_cnt", afc, frames[k]);
        if (ev) begin
          ef = 8 * int'(h == 0 && v == 0) + 4 * int'(h == 0) + 2 * int'(h == LW - 1)
             + int'(h == LW - 1 && v == FH - 1);
          check(k == 0 ? "a.pixel" : "b.pixel", apix, exp_pixel(pat[k], h, v));
          check(k == 0 ? "a.flags" : "b.flags", af, ef);
        end
      end
    end
  end

  // Waits for instance A to present a given pixel (val<0: any) optionally with sof/sol.
  task automatic wait_a(input int val, input bit need_sof, input bit need_sol);
    bit found = 0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (ifa.data_valid && (val < 0 || int'(ifa.pixel_out) == val) &&
          (!need_sof || ifa.sof) && (!need_sol || ifa.sol)) found = 1;
    end
    check("wait_a", int'(found), 1);
  endtask

  int p2 [10] = '{0, 0, 0, 0, 0, 63, 63, 63, 63, 63};
  int p3 [10] = '{63, 63, 0, 0, 63, 63, 0, 0, 63, 63};

  initial begin
    rst = 1'b1; enable = 1'b0; out_ready = 1'b1; pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    check("reset a.valid", int'(ifa.data_valid), 0);
    check("reset b.valid", int'(ifb.data_valid), 0);
    check("reset a.frame_cnt", int'(fc_a), 0);
    check("reset a.sof", int'(ifa.sof), 0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("start pixel", int'(ifa.pixel_out), 0);
    check("start sof", int'(ifa.sof), 1);
    check("start b.valid", int'(ifb.data_valid), 1);

    // Hold pixel 3 for three stalled cycles.
    wait_a(3, 0, 0);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall pixel", int'(ifa.pixel_out), 3);
      check("stall valid", int'(ifa.data_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("after stall", int'(ifa.pixel_out), 4);

    wait_a(0, 1, 0);
    check("frame_cnt after frame", int'(fc_a), 1);

    // Frame 2 is pattern 0; request pattern 2 for frame 3.
    pattern_sel = 2'd2;
    wait_a(0, 1, 0);
    for (int i = 0; i < LW; i++) begin
      check("pattern2 line", int'(ifa.pixel_out), p2[i]);
      if (i < LW - 1) @(negedge clk);
    end

    pattern_sel = 2'd3;
    wait_a(0, 1, 0);
    wait_a(-1, 0, 1);
    wait_a(-1, 0, 1);
    for (int i = 0; i < LW; i++) begin
      check("pattern3 line2", int'(ifa.pixel_out), p3[i]);
      if (i < LW - 1) @(negedge clk);
    end

    // Mid-frame pattern change must not disturb the current frame.
    pattern_sel = 2'd0;
    wait_a(25, 0, 0);
    pattern_sel = 2'd1;
    wait_a(49, 0, 0);
    check("eof on 49", int'(ifa.eof), 1);
    wait_a(0, 1, 0);
    pattern_sel = 2'd0;
    wait_a(-1, 0, 1);
    for (int i = 0; i < LW; i++) begin
      check("pattern1 line1", int'(ifa.pixel_out), i);
      if (i < LW - 1) @(negedge clk);
    end

    // Drop enable mid-frame: the frame finishes, then the source idles.
    wait_a(12, 0, 0);
    enable = 1'b0;
    wait_a(49, 0, 0);
    repeat (40) begin
      @(negedge clk);
      check("idle valid", int'(ifa.data_valid), 0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("restart pixel", int'(ifa.pixel_out), 0);
    check("restart sof", int'(ifa.sof), 1);
    check("restart b.sof", int'(ifb.sof), 1);

    // Reset mid-frame aborts at once.
    wait_a(33, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst valid", int'(ifa.data_valid), 0);
    check("rst frame_cnt", int'(fc_a), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst pixel", int'(ifa.pixel_out), 0);
    check("post-rst sof", int'(ifa.sof), 1);

    for (int i = 0; i < 300; i++) begin
      out_ready = ((i % 4) != 3);
      if (i == 100) pattern_sel = 2'd3;
      if (i == 200) pattern_sel = 2'd2;
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (150) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/raster_pixel_source.md
Name: raster_pixel_source

Overview:
Synthesizable raster-scan pixel stream generator that drives the pixel input side of line_delay and the downstream Sobel datapath. Emits one frame of LINE_WIDTH x FRAME_HEIGHT pixels in raster order, with selectable test patterns, configurable horizontal and vertical blanking, and frame/line markers. Uses a valid/ready handshake so it can be throttled by downstream stages. Serves as the on-chip stimulus source for hardware bring-up and for regression benches.

Parameters:
LINE_WIDTH, 10, active pixels per line (>=2)
FRAME_HEIGHT, 5, active lines per frame (>=2)
DATA_WIDTH, 6, pixel width in bits
H_BLANK, 2, idle cycles after each line except the last (0 allowed)
V_BLANK, 4, idle cycles after the last line of a frame (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  run request; level-sensitive
pattern_sel  in  2  0=linear index, 1=h ramp, 2=vertical edge, 3=checkerboard
out_ready  in  1  downstream can accept a pixel
pixel_out  out  DATA_WIDTH  pixel value
data_valid  out  1  pixel_out is valid
sol  out  1  first pixel of line (qualified by data_valid)
eol  out  1  last pixel of line
sof  out  1  first pixel of frame
eof  out  1  last pixel of frame
frame_cnt  out  8  completed-frame count, wraps 255->0

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs 0; FSM in IDLE; h_cnt=0, v_cnt=0. Reset asserted mid-frame aborts immediately: data_valid=0 on the cycle after the reset edge, and the next frame restarts at (0,0).
- Counters: h_cnt is $clog2(LINE_WIDTH) bits and v_cnt is $clog2(FRAME_HEIGHT) bits; blank counter is sized for max(H_BLANK,V_BLANK). All outputs are registered.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
  - IDLE: data_valid=0. When enable=1, go to ACTIVE; the first pixel (0,0) is presented one cycle after enable is sampled high.
  - ACTIVE: data_valid=1. A transfer occurs on any edge with data_valid && out_ready. Without a transfer, pixel_out and all flags hold stable. Never drop data_valid while un-transferred.
  - On transfer of h_cnt=LINE_WIDTH-1 when v_cnt<FRAME_HEIGHT-1: v_cnt++ and h_cnt=0. Go to HBLANK if H_BLANK>0, otherwise present the next line on the following cycle.
  - On transfer of the last frame pixel: frame_cnt++, v_cnt=0. Go to VBLANK if V_BLANK>0; otherwise behave as VBLANK-exit immediately.
  - HBLANK: data_valid=0 for exactly H_BLANK cycles, then ACTIVE.
  - VBLANK: data_valid=0 for exactly V_BLANK cycles. Then go to ACTIVE if enable=1, else IDLE.
- pattern_sel is latched at the start of each frame on entry to ACTIVE with v_cnt=0, h_cnt=0. Changes mid-frame take effect at the next frame.
- enable deasserted mid-frame: the frame completes, including V_BLANK, then the FSM goes to IDLE. No partial frames.
- Patterns, with MAX = 2^DATA_WIDTH-1:
  - 0: (h + v*LINE_WIDTH) mod 2^DATA_WIDTH
  - 1: h mod 2^DATA_WIDTH
  - 2: MAX if h >= LINE_WIDTH/2, else 0
  - 3: MAX if h[1]^v[1], else 0
- Flags are asserted only alongside data_valid=1:
  - sol = (h==0)
  - eol = (h==LINE_WIDTH-1)
  - sof = sol && (v==0)
  - eof = eol && (v==FRAME_HEIGHT-1)

Test Plan:
- Defaults, pattern 0, enable=1, out_ready=1 -> line 0 = 0..9 (sof/sol on 0, eol on 9); 2 cycles with valid=0; line 1 = 10..19; ... pixel 49 with eof; 4 idle cycles; next frame starts at 0 with sof; frame_cnt=1.
- Backpressure: out_ready=0 for 3 cycles while pixel 3 is presented -> pixel_out=3 and valid=1 held for all 3 cycles; sequence continues 4,5,... with no skip or duplicate transfer.
- Pattern 2 -> each line outputs 0,0,0,0,0,63,63,63,63,63. Pattern 3, line 2 -> 63,63,0,0,63,63,0,0,63,63.
- pattern_sel changed 0->1 at pixel 25 -> remainder of frame still follows pattern 0 (25..49); next frame outputs 0..9 on every line.
- enable dropped at pixel 12 -> output continues through 49, then V_BLANK, then IDLE with valid=0 held; re-assert enable -> pixel 0 with sof one cycle later.
- rst pulsed at pixel 33 -> valid=0 the next cycle and frame_cnt=0; after release with enable=1 the stream restarts at 0 with sof. Also run H_BLANK=0, V_BLANK=0 -> fully back-to-back 0..49,0..49.
